// File: rtl/crc32_pkg.sv
// Shared constants, framer state encoding and the byte-wide CRC-32 step used by
// the transmit framer (MSB-first, non-reflected, no final XOR).
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'h00000000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CRC
    } framer_state_t;

    // Eight serial shifts, data bit 7 entering first.
    function automatic logic [31:0] crc32_byte_step(input logic [31:0] crc,
                                                    input logic [7:0]  data,
                                                    input logic [31:0] poly);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int k = 0; k < 8; k++) begin
            fb = c[31] ^ data[7-k];
            c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
        end
        return c;
    endfunction

    function automatic logic [7:0] word_byte(input logic [31:0] word,
                                             input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/crc32_byte_next.sv
// Combinational next-state of the CRC-32 register for one input byte.
module crc32_byte_next
    import crc32_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY
) (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    assign crc_out = crc32_byte_step(crc_in, data, POLY);

endmodule

// File: rtl/crc32_tx_framer.sv
// Transmit framer: serialises 32-bit words MSB byte first and appends the frame CRC-32.
// The CRC register is owned here and cleared back to INIT at the end of every frame.
module crc32_tx_framer
    import crc32_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY,
    parameter logic [31:0] INIT = CRC32_INIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [31:0] crc_value,
    output logic        crc_done
);

    framer_state_t state, next_state;

    logic [31:0] word_buf;
    logic        last_flag;
    logic [1:0]  idx;
    logic [31:0] crc_reg;
    logic [31:0] emit_reg;
    logic [31:0] crc_next;
    logic [7:0]  payload_byte;

    assign payload_byte = word_byte(word_buf, idx);

    crc32_byte_next #(.POLY(POLY)) u_step (
        .crc_in  (crc_reg),
        .data    (payload_byte),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs depend only on registered state, so out_ready never reaches in_ready.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = 8'h00;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                out_valid = 1'b1;
                out_data  = payload_byte;
                if (out_ready && idx == 2'd3) begin
                    next_state = last_flag ? ST_CRC : ST_IDLE;
                end
            end
            ST_CRC: begin
                out_valid = 1'b1;
                out_data  = word_byte(emit_reg, idx);
                out_last  = (idx == 2'd3);
                if (out_ready && idx == 2'd3) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_buf  <= 32'h0;
            last_flag <= 1'b0;
            idx       <= 2'd0;
            crc_reg   <= INIT;
            emit_reg  <= 32'h0;
            crc_value <= 32'h0;
            crc_done  <= 1'b0;
        end else begin
            crc_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        word_buf  <= in_data;
                        last_flag <= in_last;
                        idx       <= 2'd0;
                    end
                end
                ST_PAYLOAD: begin
                    if (out_ready) begin
                        crc_reg <= crc_next;
                        idx     <= idx + 2'd1;
                        // The snapshot includes the final payload byte being sent now.
                        if (idx == 2'd3 && last_flag) begin
                            emit_reg <= crc_next;
                        end
                    end
                end
                ST_CRC: begin
                    if (out_ready) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            crc_value <= emit_reg;
                            crc_done  <= 1'b1;
                            crc_reg   <= INIT;
                        end
                    end
                end
                default: idx <= 2'd0;
            endcase
        end
    end

endmodule
